// File: rtl/pose_integrator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pose_integrator_pkg
// Description : Shared constants and FSM state encoding for the dead-reckoning
//               pose integrator. Holds the default word format (17-bit
//               sign-magnitude, Q8), the angle constants used by the theta
//               wrap, the largest representable magnitude, and the
//               update-sequence state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pose_integrator_pkg;

    localparam int N_WIDTH  = 17;
    localparam int Q_WIDTH  = 8;
    localparam int PI_Q     = 804;
    localparam int TWO_PI_Q = 2 * PI_Q;
    localparam int MAG_MAX  = (2 ** (N_WIDTH - 1)) - 1;

    // One pass through SAMPLE..COMMIT is a single pose update.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_ADD_X  = 3'd2,
        ST_ADD_Y  = 3'd3,
        ST_ADD_T  = 3'd4,
        ST_WRAP_T = 3'd5,
        ST_COMMIT = 3'd6
    } state_t;

endpackage : pose_integrator_pkg
`default_nettype wire

// File: rtl/pose_integrator_sm_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : sm_add_sat
// Description : Combinational sign-magnitude saturating adder. When the
//               operands have the same sign, a carry out of the magnitude
//               clamps the result to the largest magnitude and keeps that
//               sign. A zero result is always returned as +0.
// Ports       : a, b  - sign-magnitude operands (MSB = sign)
//               sum   - saturated sign-magnitude sum
// Revision    : 1.0 - initial release
// ============================================================================
module sm_add_sat
#(
    parameter int N_WIDTH = pose_integrator_pkg::N_WIDTH
)
(
    input  logic [N_WIDTH-1:0] a,
    input  logic [N_WIDTH-1:0] b,
    output logic [N_WIDTH-1:0] sum
);

    localparam int MAG_W = N_WIDTH - 1;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic [MAG_W:0]   w_mag_ext;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;

    always_comb begin
        w_sign_a  = a[N_WIDTH-1];
        w_sign_b  = b[N_WIDTH-1];
        w_mag_a   = a[MAG_W-1:0];
        w_mag_b   = b[MAG_W-1:0];
        w_mag_ext = {1'b0, w_mag_a} + {1'b0, w_mag_b};
        w_sign    = w_sign_a;
        w_mag     = '0;
        if (w_sign_a == w_sign_b) begin
            // Magnitudes add; a carry out means the result is out of range.
            w_mag = w_mag_ext[MAG_W] ? {MAG_W{1'b1}} : w_mag_ext[MAG_W-1:0];
        end else if (w_mag_a >= w_mag_b) begin
            w_mag = w_mag_a - w_mag_b;
        end else begin
            w_sign = w_sign_b;
            w_mag  = w_mag_b - w_mag_a;
        end
        sum = {w_sign & (|w_mag), w_mag};
    end

endmodule : sm_add_sat
`default_nettype wire

// File: rtl/pose_integrator.sv
`default_nettype none
// ============================================================================
// Module      : pose_integrator
// Description : Dead-reckoning odometry. Every TICK_DIV enabled cycles the
//               world-frame velocities are sampled, scaled by dt = 2^-DT_SHIFT
//               and added to the working pose one axis per cycle through a
//               single shared saturating adder. Theta is folded back into
//               [-pi, pi] and the whole pose is then committed to the outputs
//               atomically with a one-cycle UPDATE pulse.
// Ports       : CLOCK_50 / RESET_InHigh     - clock, synchronous reset
//               ENABLE_InHigh               - integration enable
//               LOAD_InHigh, INIT*_InBus    - pose preset (aborts an update)
//               VX/VY/WZ_InBus              - velocity commands
//               CURRENT*_OutBus             - committed pose
//               UPDATE_OutHigh, BUSY_OutHigh- commit pulse, sequence active
// Revision    : 1.0 - initial release
// ============================================================================
module pose_integrator
#(
    parameter int N_WIDTH  = pose_integrator_pkg::N_WIDTH,
    parameter int Q_WIDTH  = pose_integrator_pkg::Q_WIDTH,
    parameter int TICK_DIV = 390625,
    parameter int DT_SHIFT = 7,
    parameter int PI_Q     = pose_integrator_pkg::PI_Q
)
(
    input  logic               POSE_INTEGRATOR_CLOCK_50,
    input  logic               POSE_INTEGRATOR_RESET_InHigh,
    input  logic               POSE_INTEGRATOR_ENABLE_InHigh,
    input  logic               POSE_INTEGRATOR_LOAD_InHigh,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITX_InBus,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITY_InBus,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITTHETA_InBus,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_VX_InBus,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_VY_InBus,
    input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_WZ_InBus,
    output logic [N_WIDTH-1:0] POSE_INTEGRATOR_CURRENTX_OutBus,
    output logic [N_WIDTH-1:0] POSE_INTEGRATOR_CURRENTY_OutBus,
    output logic [N_WIDTH-1:0] POSE_INTEGRATOR_CURRENTTHETA_OutBus,
    output logic               POSE_INTEGRATOR_UPDATE_OutHigh,
    output logic               POSE_INTEGRATOR_BUSY_OutHigh
);

    import pose_integrator_pkg::*;

    localparam int MAG_W = N_WIDTH - 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [MAG_W-1:0] c_pi_mag     = MAG_W'(PI_Q);
    localparam logic [MAG_W-1:0] c_two_pi_mag = MAG_W'(2 * PI_Q);

    logic clk;
    logic rst;
    logic enable;
    logic load;

    assign clk    = POSE_INTEGRATOR_CLOCK_50;
    assign rst    = POSE_INTEGRATOR_RESET_InHigh;
    assign enable = POSE_INTEGRATOR_ENABLE_InHigh;
    assign load   = POSE_INTEGRATOR_LOAD_InHigh;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic               w_tick;
    logic               w_busy;
    logic               w_update;

    logic [N_WIDTH-1:0] r_work_x, r_work_y, r_work_t;
    logic [N_WIDTH-1:0] r_delta_x, r_delta_y, r_delta_t;
    logic [N_WIDTH-1:0] r_pose_x, r_pose_y, r_pose_t;
    logic [N_WIDTH-1:0] w_add_a, w_add_b, w_add_sum;

    // v * dt with truncation toward zero: shift the magnitude, keep the sign,
    // and never produce -0.
    function automatic logic [N_WIDTH-1:0] scale_velocity(input logic [N_WIDTH-1:0] v);
        logic [MAG_W-1:0] m;
        m = v[MAG_W-1:0] >> DT_SHIFT;
        return {v[N_WIDTH-1] & (|m), m};
    endfunction

    function automatic logic [N_WIDTH-1:0] drop_neg_zero(input logic [N_WIDTH-1:0] v);
        return {v[N_WIDTH-1] & (|v[MAG_W-1:0]), v[MAG_W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Integration tick: counts enabled cycles only; LOAD restarts the period.
    // ------------------------------------------------------------------
    assign w_tick = enable && (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || load || !enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Update-sequence FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != ST_IDLE);
        w_update    = 1'b0;
        if (load) begin
            // Abort: return to IDLE and suppress any commit pulse.
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   if (w_tick) w_state_nxt = ST_SAMPLE;
                ST_SAMPLE: w_state_nxt = ST_ADD_X;
                ST_ADD_X:  w_state_nxt = ST_ADD_Y;
                ST_ADD_Y:  w_state_nxt = ST_ADD_T;
                ST_ADD_T:  w_state_nxt = ST_WRAP_T;
                ST_WRAP_T: w_state_nxt = ST_COMMIT;
                ST_COMMIT: begin
                    w_state_nxt = ST_IDLE;
                    w_update    = 1'b1;
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shared adder, time-multiplexed across the three axes
    // ------------------------------------------------------------------
    always_comb begin
        w_add_a = r_work_x;
        w_add_b = r_delta_x;
        if (r_state == ST_ADD_Y) begin
            w_add_a = r_work_y;
            w_add_b = r_delta_y;
        end else if (r_state == ST_ADD_T) begin
            w_add_a = r_work_t;
            w_add_b = r_delta_t;
        end
    end

    sm_add_sat #(
        .N_WIDTH (N_WIDTH)
    ) u_add (
        .a   (w_add_a),
        .b   (w_add_b),
        .sum (w_add_sum)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work_x  <= '0;
            r_work_y  <= '0;
            r_work_t  <= '0;
            r_delta_x <= '0;
            r_delta_y <= '0;
            r_delta_t <= '0;
            r_pose_x  <= '0;
            r_pose_y  <= '0;
            r_pose_t  <= '0;
        end else if (load) begin
            r_work_x <= POSE_INTEGRATOR_INITX_InBus;
            r_work_y <= POSE_INTEGRATOR_INITY_InBus;
            r_work_t <= POSE_INTEGRATOR_INITTHETA_InBus;
            r_pose_x <= POSE_INTEGRATOR_INITX_InBus;
            r_pose_y <= POSE_INTEGRATOR_INITY_InBus;
            r_pose_t <= POSE_INTEGRATOR_INITTHETA_InBus;
        end else begin
            unique case (r_state)
                ST_SAMPLE: begin
                    r_delta_x <= scale_velocity(POSE_INTEGRATOR_VX_InBus);
                    r_delta_y <= scale_velocity(POSE_INTEGRATOR_VY_InBus);
                    r_delta_t <= scale_velocity(POSE_INTEGRATOR_WZ_InBus);
                end
                ST_ADD_X: r_work_x <= w_add_sum;
                ST_ADD_Y: r_work_y <= w_add_sum;
                ST_ADD_T: r_work_t <= w_add_sum;
                ST_WRAP_T: begin
                    // |delta| < 2 rad, so one fold by 2*pi always lands in range.
                    if (r_work_t[MAG_W-1:0] > c_pi_mag) begin
                        r_work_t <= {~r_work_t[N_WIDTH-1], c_two_pi_mag - r_work_t[MAG_W-1:0]};
                    end
                end
                ST_COMMIT: begin
                    r_pose_x <= drop_neg_zero(r_work_x);
                    r_pose_y <= drop_neg_zero(r_work_y);
                    r_pose_t <= drop_neg_zero(r_work_t);
                end
                default: ;
            endcase
        end
    end

    assign POSE_INTEGRATOR_CURRENTX_OutBus     = r_pose_x;
    assign POSE_INTEGRATOR_CURRENTY_OutBus     = r_pose_y;
    assign POSE_INTEGRATOR_CURRENTTHETA_OutBus = r_pose_t;
    assign POSE_INTEGRATOR_UPDATE_OutHigh      = w_update;
    assign POSE_INTEGRATOR_BUSY_OutHigh        = w_busy;

    // A tick can only land in IDLE when the period exceeds the sequence length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (TICK_DIV >= 8);
            assert (Q_WIDTH < MAG_W);
            assert (!(w_tick && w_busy));
        end
    end

endmodule : pose_integrator
`default_nettype wire

// File: doc/pose_integrator.md
Name: pose_integrator

Overview:
- Dead-reckoning odometry block that closes the position loop.
- Consumes the world-frame velocity commands (VX, VY, WZ) produced by the position controller and integrates them into the current pose (X, Y, THETA).
- The resulting pose feeds back into the controller's CURRENT inputs.
- All data is 17-bit sign-magnitude fixed point, Q8: MSB is the sign, the low 16 bits are the magnitude, 8 of them fractional.

Parameters:
- N_WIDTH, 17: total word width.
- Q_WIDTH, 8: fractional bits.
- TICK_DIV, 390625: clock cycles per integration step. Default gives 7.8125 ms at 50 MHz. Must be >= 8.
- DT_SHIFT, 7: integration step dt = 2^-DT_SHIFT s. Must match TICK_DIV.
- PI_Q, 804: pi in Q8.

Ports:
- POSE_INTEGRATOR_CLOCK_50  in  1  system clock.
- POSE_INTEGRATOR_RESET_InHigh  in  1  synchronous, active-high reset.
- POSE_INTEGRATOR_ENABLE_InHigh  in  1  integration enable.
- POSE_INTEGRATOR_LOAD_InHigh  in  1  preset pose from INIT buses.
- POSE_INTEGRATOR_INITX_InBus  in  N_WIDTH  preset X.
- POSE_INTEGRATOR_INITY_InBus  in  N_WIDTH  preset Y.
- POSE_INTEGRATOR_INITTHETA_InBus  in  N_WIDTH  preset theta (rad).
- POSE_INTEGRATOR_VX_InBus  in  N_WIDTH  world-frame x velocity.
- POSE_INTEGRATOR_VY_InBus  in  N_WIDTH  world-frame y velocity.
- POSE_INTEGRATOR_WZ_InBus  in  N_WIDTH  angular velocity.
- POSE_INTEGRATOR_CURRENTX_OutBus  out  N_WIDTH  pose X.
- POSE_INTEGRATOR_CURRENTY_OutBus  out  N_WIDTH  pose Y.
- POSE_INTEGRATOR_CURRENTTHETA_OutBus  out  N_WIDTH  pose theta.
- POSE_INTEGRATOR_UPDATE_OutHigh  out  1  one-cycle pulse when a new pose is committed.
- POSE_INTEGRATOR_BUSY_OutHigh  out  1  high while an update sequence is in flight.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all pose outputs 0, UPDATE 0, BUSY 0, tick counter 0, FSM in IDLE.
- Tick counter:
  - Counts only while ENABLE=1 and is cleared while ENABLE=0.
  - Reaching TICK_DIV-1 produces a one-cycle tick and the counter wraps to 0.
- FSM states: IDLE, SAMPLE, ADD_X, ADD_Y, ADD_T, WRAP_T, COMMIT.
  - IDLE -> SAMPLE on tick.
  - Each subsequent state advances unconditionally one per cycle; COMMIT -> IDLE.
  - BUSY=1 in every state except IDLE.
- SAMPLE:
  - Latch VX/VY/WZ.
  - Compute each delta: magnitude >> DT_SHIFT, sign kept (truncation toward zero).
  - A zero magnitude forces sign 0.
- ADD_X / ADD_Y / ADD_T:
  - Working register = working register + delta.
  - Uses one shared sign-magnitude saturating adder.
  - On overflow, magnitude clamps to 2^(N_WIDTH-1)-1 with the sum's sign.
- WRAP_T:
  - If theta magnitude > PI_Q: magnitude <- 2*PI_Q - magnitude and the sign is inverted.
  - A single correction suffices because |delta| < 2 rad.
  - Magnitude exactly PI_Q is left unchanged.
- COMMIT:
  - Copy all three working registers to the outputs in the same cycle (atomic pose update).
  - Normalize -0 to +0.
  - Pulse UPDATE for exactly one cycle.
- Latency: tick to UPDATE is 6 cycles. Outputs never change outside COMMIT or LOAD.
- LOAD:
  - Highest priority below reset, honoured in any state.
  - Aborts any sequence in flight: no UPDATE pulse is issued.
  - Next cycle, INIT values appear in both working and output registers, the tick counter is cleared, and the FSM is in IDLE.
  - INIT theta is loaded unmodified; wrapping applies from the next update.
- Tick while BUSY: cannot occur, since TICK_DIV >= 8. The parameter constraint is checked by assertion.
- Velocities that change during a sequence are ignored until the next SAMPLE.

Decomposition:
- Shared package holds:
  - N_WIDTH and Q_WIDTH defaults.
  - PI_Q, TWO_PI_Q (1608), and MAG_MAX (2^(N_WIDTH-1)-1).
  - FSM state encoding.
- One sub-module: sm_add_sat.
  - Combinational sign-magnitude saturating adder, N_WIDTH-wide.
  - Outputs +0 for zero.
  - Instantiated once and time-multiplexed across ADD_X/ADD_Y/ADD_T.

Test Plan:
- Reset: assert RESET_InHigh for 2 cycles with ENABLE=1 -> all outputs 0, UPDATE and BUSY 0; first tick arrives TICK_DIV cycles after release.
- Forward integration (TICK_DIV=16): LOAD X=0x00100 (1.0), VX=0x00100 (+1.0), ENABLE=1 -> each UPDATE has X +2 LSB, arriving 6 cycles after its tick; after 128 updates X=0x00200 (2.0), Y and THETA remain 0.
- Zero crossing: LOAD X=0x00080 (0.5), VX=0x10100 (-1.0) -> after 64 updates X=0x00000 (no -0); after 65 updates X=0x10002.
- Theta wrap: LOAD THETA=0x00320 (800), WZ=0x00200 (+2.0) -> first update THETA=0x00324 (804, unchanged); second update THETA=0x10320 (-800).
- Saturation: LOAD X=0x0FFFF, VX=0x0FFFF -> X stays 0x0FFFF on every update; with VX=0x1FFFF, X decreases by 511 LSB per update.
- LOAD mid-sequence: assert LOAD during ADD_Y with INIT=(0x00A00, 0x10500, 0x00100) -> no UPDATE pulse; next cycle outputs equal INIT and BUSY=0; next UPDATE occurs TICK_DIV+6 cycles later.
